// File: rtl/mdu_iter_pkg.sv
// Shared M-extension definitions for the iterative multiply/divide unit:
// funct3 op codes, FSM state encodings and small op-decode helpers.
package mdu_iter_pkg;

    localparam int CNT_W = 6;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } mdu_state_e;

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_is_rem(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

    // MULH, MULHSU and MULHU return the upper product word
    function automatic logic op_is_hi(input logic [2:0] op);
        return !op[2] && (op != MDU_MUL);
    endfunction

endpackage

// File: rtl/mdu_iter_if.sv
// Request/response bundle between EX-stage control and the multiply/divide unit.
interface mdu_iter_if #(parameter int DATAW = 32);
    logic             start;
    logic [2:0]       op;
    logic [DATAW-1:0] a;
    logic [DATAW-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [DATAW-1:0] out;

    modport master (output start, op, a, b, input ready, busy, done, out);
    modport slave  (input start, op, a, b, output ready, busy, done, out);
endinterface

// File: rtl/mdu_signfix.sv
// Conditional two's-complement negate, used for operand magnitudes and
// for sign correction of the final result.
module mdu_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle RV32M multiply/divide unit, one bit per cycle (shift-add / restoring).
// Define MDU_FAST_MUL_EN for a single-cycle multiply path; divide is unaffected.
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int DATAW = 32
) (
    input  logic       clk,
    input  logic       rst,
    mdu_iter_if.slave  bus
);

    mdu_state_e         state;
    logic [2:0]         op_q;
    logic [CNT_W-1:0]   cnt;
    logic [2*DATAW-1:0] acc;
    logic [DATAW-1:0]   bmag;
    logic               neg_q;
    logic               neg_r;
    logic               spec_q;
    logic [DATAW-1:0]   spec_res;
    logic               ready_q;
    logic               busy_q;
    logic               done_q;
    logic [DATAW-1:0]   out_q;

    logic               a_sgn;
    logic               b_sgn;
    logic [DATAW-1:0]   a_mag;
    logic [DATAW-1:0]   b_mag;
    logic               div_zero;
    logic               div_ovf;
    logic               special;
    logic [DATAW-1:0]   spec_val;

    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (bus.op)
            MDU_MULH, MDU_DIV, MDU_REM: begin
                a_sgn = bus.a[DATAW-1];
                b_sgn = bus.b[DATAW-1];
            end
            MDU_MULHSU: a_sgn = bus.a[DATAW-1];
            default: ;
        endcase
    end

    mdu_signfix #(.W(DATAW)) u_fix_a (.val(bus.a), .neg(a_sgn), .res(a_mag));
    mdu_signfix #(.W(DATAW)) u_fix_b (.val(bus.b), .neg(b_sgn), .res(b_mag));

    // Divide-by-zero and the signed -2^(W-1)/-1 overflow bypass the iteration
    assign div_zero = (bus.b == '0);
    assign div_ovf  = ((bus.op == MDU_DIV) || (bus.op == MDU_REM)) &&
                      (bus.a == {1'b1, {(DATAW-1){1'b0}}}) && (bus.b == '1);
    assign special  = op_is_div(bus.op) && (div_zero || div_ovf);

    always_comb begin
        if (div_zero)
            spec_val = op_is_rem(bus.op) ? bus.a : '1;
        else
            spec_val = op_is_rem(bus.op) ? '0 : bus.a;
    end

    // Shift-add step: multiplier in the low word, partial product in the high word
    logic [DATAW:0]     mul_sum;
    logic [2*DATAW-1:0] mul_next;

    assign mul_sum  = acc[0] ? ({1'b0, acc[2*DATAW-1:DATAW]} + {1'b0, bmag})
                             : {1'b0, acc[2*DATAW-1:DATAW]};
    assign mul_next = {mul_sum, acc[DATAW-1:1]};

    // Restoring step: remainder in the high word, dividend/quotient in the low word
    logic [DATAW:0]     div_sh;
    logic               div_ge;
    logic [DATAW-1:0]   div_diff;
    logic [2*DATAW-1:0] div_next;

    assign div_sh   = {acc[2*DATAW-1:DATAW], acc[DATAW-1]};
    assign div_ge   = (div_sh >= {1'b0, bmag});
    assign div_diff = div_sh[DATAW-1:0] - bmag;
    assign div_next = {(div_ge ? div_diff : div_sh[DATAW-1:0]), acc[DATAW-2:0], div_ge};

    logic [2*DATAW-1:0] fix_in;
    logic               fix_neg;
    logic [2*DATAW-1:0] fix_out;
    logic [DATAW-1:0]   res_w;

    always_comb begin
        if (op_is_div(op_q))
            fix_in = {{DATAW{1'b0}},
                      (op_is_rem(op_q) ? acc[2*DATAW-1:DATAW] : acc[DATAW-1:0])};
        else
            fix_in = acc;
    end

    assign fix_neg = op_is_rem(op_q) ? neg_r : neg_q;

    mdu_signfix #(.W(2*DATAW)) u_fix_res (.val(fix_in), .neg(fix_neg), .res(fix_out));

    assign res_w = op_is_hi(op_q) ? fix_out[2*DATAW-1:DATAW] : fix_out[DATAW-1:0];

`ifdef MDU_FAST_MUL_EN
    logic signed [DATAW:0]     fa;
    logic signed [DATAW:0]     fb;
    logic signed [2*DATAW-1:0] fprod;

    assign fa    = {a_sgn, bus.a};
    assign fb    = {b_sgn, bus.b};
    assign fprod = (2*DATAW)'(fa) * (2*DATAW)'(fb);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            cnt      <= '0;
            acc      <= '0;
            bmag     <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            spec_q   <= 1'b0;
            spec_res <= '0;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            out_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        neg_q    <= a_sgn ^ b_sgn;
                        neg_r    <= a_sgn;
                        bmag     <= b_mag;
                        acc      <= {{DATAW{1'b0}}, a_mag};
                        cnt      <= CNT_W'(DATAW);
                        spec_q   <= special;
                        spec_res <= spec_val;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                        if (special) begin
                            state <= FIN;
`ifdef MDU_FAST_MUL_EN
                        end else if (!op_is_div(bus.op)) begin
                            acc   <= fprod;
                            neg_q <= 1'b0;
                            state <= FIN;
`endif
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc <= op_is_div(op_q) ? div_next : mul_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= FIN;
                end
                FIN: begin
                    out_q   <= spec_q ? spec_res : res_w;
                    done_q  <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.out   = out_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Multi-cycle RV32M multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Accepts funct3-encoded M-extension ops with a start/ready handshake and iterates one bit per cycle.
- Returns the result with a one-cycle done pulse; the pipeline control stalls EX while busy is high.

Parameters:
- DATAW, 32, operand/result width; iteration count equals DATAW; only 32 is supported, and the counter is sized by a localparam of 6 bits.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; accepted only when ready is high
- op  input  3  M-extension funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- a  input  DATAW  operand A (rs1), sampled on accept
- b  input  DATAW  operand B (rs2), sampled on accept
- ready  output  1  high in IDLE
- busy  output  1  high in RUN or FIN
- done  output  1  one-cycle pulse; result valid in this cycle
- out  output  DATAW  result; holds its value until the next done

Behaviour:
- Reset: state=IDLE; ready=1, busy=0, done=0, out=0; counter and internal registers cleared.
- Reset has priority over every other event; reset mid-operation aborts with no done pulse.
- States:
  - IDLE: start=1 latches op, a, b, takes signs per op, converts operands to magnitudes, loads counter=DATAW, goes to RUN. Special-case divides go directly to FIN instead.
  - RUN: one iteration per cycle, counter decrements; when counter reaches 1, go to FIN after that iteration.
  - FIN: apply sign correction, select high/low word or quotient/remainder, register into out, pulse done, return to IDLE.
- Latency: start accept cycle = T; done asserted at T+DATAW+1 (33 cycles).
- Special divides have done at T+1.
- start while busy is ignored; no queueing.
- start is accepted in the same cycle done is high (FIN->IDLE happens first, so ready is low in FIN; the new start is seen the next cycle).
- Multiply:
  - Shift-add on a 2*DATAW accumulator with unsigned magnitudes.
  - Final negate when the operand signs differ (MULH: both signed; MULHSU: a signed; MULHU: none).
  - MUL returns low word; MULH* return high word.
- Divide:
  - Restoring shift-subtract with unsigned magnitudes.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Boundaries:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU result = a.
  - Signed overflow (a = -2^(DATAW-1), b = -1): DIV result = a; REM result = 0.
  - a = 0: normal path, result 0.
- Op encodings: M-extension funct3 constants from the shared define header. Any op value is legal (3-bit space fully decoded).

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- When defined:
  - Multiply ops use a single-cycle 2*DATAW signed/unsigned product from sign-extended 33-bit operands.
  - Path is IDLE -> FIN; done at T+1.
  - Divide behaviour is unchanged.
- When undefined: iterative multiply as described in Behaviour; 33-cycle latency.

Decomposition:
- Shared define header (same file as the ALU select codes) gains:
  - MDU_MUL .. MDU_REMU funct3 constants (3'b000..3'b111).
  - MDU state encodings IDLE=2'd0, RUN=2'd1, FIN=2'd2.
- One sub-module: mdu_signfix. It is combinational and does conditional two's-complement negate of a DATAW-wide value; it is instantiated for operand magnitude and result correction.
- Control FSM and datapath stay in mdu_iter.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> done at T+33, out=0xFFFFFFEB. MULHU 0xFFFFFFFF*0xFFFFFFFF -> out=0xFFFFFFFE.
- MULH 0x80000000*0x80000000 -> out=0x40000000. MULHSU a=-1, b=0xFFFFFFFF -> out=0xFFFFFFFF.
- DIV -7/2 -> out=0xFFFFFFFD (-3). REM -7/2 -> out=0xFFFFFFFF (-1). DIVU 100/7 -> out=14. REMU 100/7 -> out=2.
- DIV 5/0 -> out=0xFFFFFFFF, done at T+1. REM 5/0 -> out=5. DIV 0x80000000/-1 -> out=0x80000000. REM of the same operands -> out=0.
- start held high while busy with different operands -> ignored; first result is unchanged. rst asserted at cycle T+10 -> no done pulse; next cycle ready=1, out=0.
- With MDU_FAST_MUL_EN: MUL 123*456 -> out=56088, done at T+1. Back-to-back MUL ops are accepted every 2 cycles.
